system_group_controller: RTL and testbench

//  Parametrised successor of the system-group decoder. Decodes NOP/EI/DI/RETI/HALT in the

---
 rtl/system_group_controller_pkg.sv | 23 ++
 rtl/system_group_controller_irq_priority_encoder.sv | 21 ++
 rtl/system_group_controller.sv | 148 ++++++++++++++
 tb/tb_system_group_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/system_group_controller_pkg.sv
// Shared constants for the system-group controller: instruction fields,
// system opcodes and HALT FSM state encodings.
package system_group_controller_pkg;

    localparam int GROUP_MSB = 15;
    localparam int GROUP_LSB = 14;
    localparam int OP_MSB    = 10;
    localparam int OP_LSB    = 8;

    localparam logic [1:0] GROUP_SYSTEM = 2'b11;

    localparam logic [2:0] GEN_OP_NOP  = 3'd0;
    localparam logic [2:0] GEN_OP_EI   = 3'd1;
    localparam logic [2:0] GEN_OP_DI   = 3'd2;
    localparam logic [2:0] GEN_OP_RETI = 3'd3;
    localparam logic [2:0] GEN_OP_HALT = 3'd4;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } sg_state_e;

endpackage

// File: rtl/system_group_controller_irq_priority_encoder.sv
// Lowest-set-bit priority encoder: index 0 wins. Used for the interrupt
// winner and for the innermost in-service level.
module irq_priority_encoder #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = {IW{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx = req[i] ? IW'(i) : idx;
        end
        valid = |req;
    end

endmodule

// File: rtl/system_group_controller.sv
// System-group decoder (NOP/EI/DI/RETI/HALT) with interrupt-enable flag,
// HALT state and N prioritised, nestable interrupt channels.
module system_group_controller
    import system_group_controller_pkg::*;
#(
    parameter int               N_IRQ         = 4,
    parameter int               NEST_DEPTH    = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK     = {N_IRQ{1'b0}},
    parameter int               SYNC_STAGES   = 2,
    parameter logic [15:0]      VECTOR_BASE   = 16'h0008,
    parameter int               VECTOR_STRIDE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic [15:0]      instruction,
    input  logic             fetch,
    input  logic             decode,
    input  logic             execute,
    input  logic             commit,
    input  logic [N_IRQ-1:0] irq,
    input  logic             int_ack,
    output logic             eix,
    output logic             dix,
    output logic             retix,
    output logic             pc_enx,
    output logic             halted,
    output logic             int_req,
    output logic [15:0]      int_vector,
    output logic             ie
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_r;
    logic [N_IRQ-1:0] synced_prev_r, edge_pend_r, isr_r;
    logic             ie_r;
    sg_state_e        state_r;

    logic [N_IRQ-1:0] synced_s, rise_s, pending_s, below_s, eligible_s, ack_mask_s;
    logic [N_IRQ-1:0] edge_pend_n_s, isr_n_s, reti_mask_s;
    logic [IW-1:0]    lvl_idx_s, win_idx_s;
    logic             lvl_valid_s, win_valid_s, run_s, sys_s, live_s, ack_s;
    logic             ei_c_s, di_c_s, reti_c_s, halt_c_s, ie_n_s, unused_ok_s;
    logic [2:0]       op_s;
    int               isr_cnt_s;
    sg_state_e        state_n_s;

    // Decode is suppressed entirely while halted.
    assign run_s    = (state_r == ST_RUN);
    assign sys_s    = run_s && (instruction[GROUP_MSB:GROUP_LSB] == GROUP_SYSTEM);
    assign op_s     = instruction[OP_MSB:OP_LSB];
    assign live_s   = decode | execute | commit;
    assign eix      = sys_s && live_s && (op_s == GEN_OP_EI);
    assign dix      = sys_s && live_s && (op_s == GEN_OP_DI);
    assign retix    = sys_s && live_s && (op_s == GEN_OP_RETI);
    assign ei_c_s   = sys_s && commit && (op_s == GEN_OP_EI);
    assign di_c_s   = sys_s && commit && (op_s == GEN_OP_DI);
    assign reti_c_s = sys_s && commit && (op_s == GEN_OP_RETI);
    assign halt_c_s = sys_s && commit && (op_s == GEN_OP_HALT);
    assign unused_ok_s = ^{fetch, instruction[13:11], instruction[7:0]};

    assign synced_s  = sync_r[SYNC_STAGES-1];
    assign rise_s    = synced_s & ~synced_prev_r & EDGE_MASK;
    assign pending_s = (edge_pend_r & EDGE_MASK) | (synced_s & ~EDGE_MASK);

    irq_priority_encoder #(.N(N_IRQ)) u_level (
        .req   (isr_r),
        .idx   (lvl_idx_s),
        .valid (lvl_valid_s)
    );

    irq_priority_encoder #(.N(N_IRQ)) u_winner (
        .req   (eligible_s),
        .idx   (win_idx_s),
        .valid (win_valid_s)
    );

    // Eligibility: strictly above the innermost in-service level and below the nest limit.
    always_comb begin
        isr_cnt_s = 0;
        for (int i = 0; i < N_IRQ; i++) begin
            isr_cnt_s = isr_cnt_s + int'(isr_r[i]);
        end
        below_s    = lvl_valid_s ? ((N_IRQ'(1'b1) << lvl_idx_s) - N_IRQ'(1'b1)) : {N_IRQ{1'b1}};
        eligible_s = (isr_cnt_s < NEST_DEPTH) ? (pending_s & below_s) : {N_IRQ{1'b0}};
    end

    assign int_req    = run_s && ie_r && win_valid_s && commit && !di_c_s;
    assign int_vector = int_req ? (VECTOR_BASE + 16'(win_idx_s) * 16'(VECTOR_STRIDE)) : 16'h0000;
    assign ack_s      = int_ack && int_req;
    assign ack_mask_s = ack_s ? (N_IRQ'(1'b1) << win_idx_s) : {N_IRQ{1'b0}};
    assign ie         = ie_r;
    assign pc_enx     = (state_r == ST_RUN);
    assign halted     = (state_r == ST_HALT);

    // Next-state for IE, in-service set, edge-pending latches and HALT FSM.
    always_comb begin
        ie_n_s = ie_r;
        if (ack_s) begin
            ie_n_s = 1'b0;
        end else if (di_c_s) begin
            ie_n_s = 1'b0;
        end else if (ei_c_s || reti_c_s) begin
            ie_n_s = 1'b1;
        end else begin
            ie_n_s = ie_r;
        end

        reti_mask_s   = (reti_c_s && lvl_valid_s) ? (N_IRQ'(1'b1) << lvl_idx_s) : {N_IRQ{1'b0}};
        isr_n_s       = (isr_r & ~reti_mask_s) | ack_mask_s;
        edge_pend_n_s = ((edge_pend_r & ~ack_mask_s) | rise_s) & EDGE_MASK;

        state_n_s = state_r;
        case (state_r)
            ST_RUN:  state_n_s = halt_c_s ? ST_HALT : ST_RUN;
            ST_HALT: state_n_s = (|pending_s) ? ST_RUN : ST_HALT;
            default: state_n_s = ST_RUN;
        endcase
    end

    // State registers with async reset and synchronous soft reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r        <= '0;
            synced_prev_r <= {N_IRQ{1'b0}};
            edge_pend_r   <= {N_IRQ{1'b0}};
            isr_r         <= {N_IRQ{1'b0}};
            ie_r          <= 1'b0;
            state_r       <= ST_RUN;
        end else if (srst) begin
            sync_r        <= '0;
            synced_prev_r <= {N_IRQ{1'b0}};
            edge_pend_r   <= {N_IRQ{1'b0}};
            isr_r         <= {N_IRQ{1'b0}};
            ie_r          <= 1'b0;
            state_r       <= ST_RUN;
        end else begin
            sync_r        <= {sync_r[SYNC_STAGES-2:0], irq};
            synced_prev_r <= synced_s;
            edge_pend_r   <= edge_pend_n_s;
            isr_r         <= isr_n_s;
            ie_r          <= ie_n_s;
            state_r       <= state_n_s;
        end
    end

endmodule

// File: tb/tb_system_group_controller.sv
// Directed bench for system_group_controller: phase-sequenced instructions,
// interrupt nesting, HALT wake-up and asynchronous reset.
module tb_system_group_controller;

    localparam logic [15:0] I_NOP  = 16'hC000;
    localparam logic [15:0] I_EI   = 16'hC100;
    localparam logic [15:0] I_DI   = 16'hC200;
    localparam logic [15:0] I_RETI = 16'hC300;
    localparam logic [15:0] I_HALT = 16'hC400;
    localparam logic [15:0] I_MOV  = 16'h4100;

    logic        clk = 1'b0;
    logic        rst_n, srst;
    logic [15:0] instruction;
    logic        fetch, decode, execute, commit, int_ack;
    logic [3:0]  irq;
    logic        eix, dix, retix, pc_enx, halted, int_req, ie;
    logic [15:0] int_vector;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        ob_fetch_any, ob_eix, ob_dix, ob_retix, ob_req;
    logic [15:0] ob_vec;
    bit          woke;

    system_group_controller #(
        .N_IRQ(4), .NEST_DEPTH(2), .EDGE_MASK(4'b0010), .SYNC_STAGES(2),
        .VECTOR_BASE(16'h0008), .VECTOR_STRIDE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .srst(srst), .instruction(instruction),
        .fetch(fetch), .decode(decode), .execute(execute), .commit(commit),
        .irq(irq), .int_ack(int_ack), .eix(eix), .dix(dix), .retix(retix),
        .pc_enx(pc_enx), .halted(halted), .int_req(int_req),
        .int_vector(int_vector), .ie(ie)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one instruction through FETCH/DECODE/EXECUTE/COMMIT, one cycle each.
    task automatic run_instr(input logic [15:0] ins, input logic ack);
        instruction = ins;
        fetch = 1'b1;
        @(negedge clk);
        ob_fetch_any = eix | dix | retix;
        @(posedge clk); #1;
        fetch = 1'b0; decode = 1'b1;
        @(negedge clk);
        ob_eix = eix; ob_dix = dix; ob_retix = retix;
        @(posedge clk); #1;
        decode = 1'b0; execute = 1'b1;
        @(posedge clk); #1;
        execute = 1'b0; commit = 1'b1;
        @(negedge clk);
        ob_req = int_req; ob_vec = int_vector;
        int_ack = ack;
        @(posedge clk); #1;
        commit = 1'b0; int_ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; srst = 1'b0; instruction = 16'h0000; irq = 4'b0000;
        fetch = 1'b0; decode = 1'b0; execute = 1'b0; commit = 1'b0; int_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_val("rst_pc_enx", 32'(pc_enx), 32'd1);
        check_val("rst_halted", 32'(halted), 32'd0);
        check_val("rst_ie", 32'(ie), 32'd0);
        check_val("rst_int_req", 32'(int_req), 32'd0);
        check_val("rst_vector", 32'(int_vector), 32'd0);

        // 1: NOP and a non-system instruction have no effect
        run_instr(I_NOP, 1'b0);
        check_val("nop_eix", 32'(ob_eix), 32'd0);
        check_val("nop_pc", 32'(pc_enx), 32'd1);
        run_instr(I_MOV, 1'b0);
        check_val("mov_flags", 32'({ob_eix, ob_dix, ob_retix}), 32'd0);
        check_val("mov_ie", 32'(ie), 32'd0);

        // 2: EI then level IRQ2
        run_instr(I_EI, 1'b0);
        check_val("ei_fetch", 32'(ob_fetch_any), 32'd0);
        check_val("ei_decode", 32'(ob_eix), 32'd1);
        check_val("ei_ie", 32'(ie), 32'd1);
        irq[2] = 1'b1; idle(4);
        run_instr(I_NOP, 1'b1);
        check_val("ch2_req", 32'(ob_req), 32'd1);
        check_val("ch2_vec", 32'(ob_vec), 32'h0010);
        check_val("ch2_ack_ie", 32'(ie), 32'd0);

        // 3: nesting above ch2
        run_instr(I_EI, 1'b0);
        irq[3] = 1'b1; idle(4);
        run_instr(I_NOP, 1'b0);
        check_val("ch3_masked", 32'(ob_req), 32'd0);
        irq[0] = 1'b1; idle(4);
        run_instr(I_NOP, 1'b1);
        check_val("ch0_req", 32'(ob_req), 32'd1);
        check_val("ch0_vec", 32'(ob_vec), 32'h0008);
        run_instr(I_EI, 1'b0);
        run_instr(I_NOP, 1'b0);
        check_val("third_blocked", 32'(ob_req), 32'd0);
        run_instr(I_RETI, 1'b0);
        check_val("reti_decode", 32'(ob_retix), 32'd1);
        run_instr(I_NOP, 1'b0);
        check_val("reti1_ch0_free", 32'({ob_req, ob_vec}), 32'h10008);
        irq[0] = 1'b0; irq[3] = 1'b0; idle(4);
        run_instr(I_RETI, 1'b0);
        run_instr(I_NOP, 1'b1);
        check_val("reti2_ch2_free", 32'({ob_req, ob_vec}), 32'h10010);

        // 4: HALT with IE=0, edge IRQ1 wakes without a request
        irq[2] = 1'b0; idle(4);
        run_instr(I_HALT, 1'b0);
        check_val("halt_halted", 32'(halted), 32'd1);
        check_val("halt_pc", 32'(pc_enx), 32'd0);
        run_instr(I_EI, 1'b0);
        check_val("halt_no_decode", 32'({ob_eix, ie, halted}), 32'd1);
        irq[1] = 1'b1; idle(1); irq[1] = 1'b0;
        woke = 1'b0;
        for (int c = 0; c < 20 && !woke; c++) begin
            idle(1);
            woke = !halted;
        end
        check_val("wake_halted", 32'(halted), 32'd0);
        check_val("wake_pc", 32'(pc_enx), 32'd1);
        run_instr(I_NOP, 1'b0);
        check_val("wake_no_req", 32'(ob_req), 32'd0);

        // nest limit: ch2 and ch1 in service blocks ch0
        run_instr(I_EI, 1'b0);
        run_instr(I_NOP, 1'b1);
        check_val("ch1_vec", 32'({ob_req, ob_vec}), 32'h1000C);
        run_instr(I_EI, 1'b0);
        irq[0] = 1'b1; idle(4);
        run_instr(I_NOP, 1'b0);
        check_val("depth_block", 32'(ob_req), 32'd0);
        run_instr(I_RETI, 1'b0);
        run_instr(I_NOP, 1'b0);
        check_val("depth_release", 32'({ob_req, ob_vec}), 32'h10008);

        // 5: DI beats an eligible IRQ; RETI on empty in-service
        run_instr(I_RETI, 1'b0);
        run_instr(I_DI, 1'b0);
        check_val("di_decode", 32'(ob_dix), 32'd1);
        check_val("di_no_req", 32'(ob_req), 32'd0);
        check_val("di_ie", 32'(ie), 32'd0);
        run_instr(I_RETI, 1'b0);
        check_val("reti_empty_ie", 32'(ie), 32'd1);
        run_instr(I_NOP, 1'b0);
        check_val("reti_empty_isr", 32'({ob_req, ob_vec}), 32'h10008);

        // 6: async reset during a held request
        instruction = I_NOP; commit = 1'b1;
        @(negedge clk);
        check_val("pre_rst_req", 32'(int_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_req", 32'({int_req, int_vector}), 32'd0);
        check_val("arst_ie_pc", 32'({ie, pc_enx, halted}), 32'b010);
        commit = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // soft reset clears IE
        run_instr(I_EI, 1'b0);
        srst = 1'b1; idle(1); srst = 1'b0;
        check_val("srst_ie", 32'(ie), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
